// File: rtl/instr_hazard_pipe_if.sv
// D-stage request and hazard/scoreboard status bundle for instr_hazard_pipe.
// The master side drives the decode-stage instruction and flush; the slave reports stall and stage state.
interface instr_hazard_pipe_if #(
  parameter int DEPTH = 3
);
  logic [31:0]        instr_d;
  logic               valid_d;
  logic               flush;
  logic               stall;
  logic [DEPTH-1:0]   stage_valid;
  logic [5*DEPTH-1:0] stage_dst;
  logic [DEPTH-1:0]   stage_load;
  logic               md_busy;
  logic [4:0]         md_count;

  modport master (
    output instr_d, valid_d, flush,
    input  stall, stage_valid, stage_dst, stage_load, md_busy, md_count
  );

  modport slave (
    input  instr_d, valid_d, flush,
    output stall, stage_valid, stage_dst, stage_load, md_busy, md_count
  );
endinterface

// File: rtl/instr_hazard_pipe.sv
// MIPS-I hazard unit: decodes the D-stage instruction, tracks destinations of the
// DEPTH stages after D, and raises a zero-latency stall for RAW, branch, HI/LO and EPC hazards.
module instr_hazard_pipe #(
  parameter int DEPTH    = 3,
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input logic               clk,
  input logic               reset_n,
  instr_hazard_pipe_if.slave bus
);

  typedef struct packed {
    logic       vld;
    logic [4:0] dst;
    logic       load;
    logic       mdcal;
    logic       md_div;
    logic       epc_wr;
  } stage_t;

  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd;

  logic cal_r, cal_i, load, store, branch, jr, jal, jalr;
  logic mfhl, mthl, mdcal, mfc0, mtc0, eret;
  logic shift_imm, lui, beq_bne, md_div;
  logic rd_rs, rd_rt;
  logic [4:0] dst_d;
  logic unused_shamt;

  stage_t     stage_p [DEPTH];
  stage_t     rec_d;
  logic [4:0] md_count_p;

  logic use_s1, use_s2;
  logic load_use, br_haz, md_haz, epc_haz;

  assign op    = bus.instr_d[31:26];
  assign rs    = bus.instr_d[25:21];
  assign rt    = bus.instr_d[20:16];
  assign rd    = bus.instr_d[15:11];
  assign funct = bus.instr_d[5:0];
  assign unused_shamt = ^bus.instr_d[10:6];

  always_comb begin
    cal_r = 1'b0; cal_i = 1'b0; load = 1'b0; store = 1'b0;
    branch = 1'b0; jr = 1'b0; jal = 1'b0; jalr = 1'b0;
    mfhl = 1'b0; mthl = 1'b0; mdcal = 1'b0; mfc0 = 1'b0; mtc0 = 1'b0; eret = 1'b0;
    shift_imm = 1'b0; lui = 1'b0; beq_bne = 1'b0; md_div = 1'b0;
    case (op)
      6'b000000: begin
        case (funct)
          6'b000000, 6'b000010, 6'b000011: begin cal_r = 1'b1; shift_imm = 1'b1; end
          6'b000100, 6'b000110, 6'b000111,
          6'b100000, 6'b100001, 6'b100010, 6'b100011,
          6'b100100, 6'b100101, 6'b100110, 6'b100111,
          6'b101010, 6'b101011:             cal_r = 1'b1;
          6'b001000:                        jr    = 1'b1;
          6'b001001:                        jalr  = 1'b1;
          6'b010000, 6'b010010:             mfhl  = 1'b1;
          6'b010001, 6'b010011:             mthl  = 1'b1;
          6'b011000, 6'b011001:             mdcal = 1'b1;
          6'b011010, 6'b011011: begin mdcal = 1'b1; md_div = 1'b1; end
          default: ;
        endcase
      end
      6'b000001: branch = (rt[4:1] == 4'b0000);
      6'b000011: jal = 1'b1;
      6'b000100, 6'b000101: begin branch = 1'b1; beq_bne = 1'b1; end
      6'b000110, 6'b000111: branch = 1'b1;
      6'b001000, 6'b001001, 6'b001010, 6'b001011,
      6'b001100, 6'b001101, 6'b001110: cal_i = 1'b1;
      6'b001111: begin cal_i = 1'b1; lui = 1'b1; end
      6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101: load = 1'b1;
      6'b101000, 6'b101001, 6'b101011: store = 1'b1;
      6'b010000: begin
        // COP0: CO bit set selects the eret function, otherwise rs picks mfc0/mtc0
        if (bus.instr_d[25] && funct == 6'b011000) eret = 1'b1;
        else if (rs == 5'b00000)                    mfc0 = 1'b1;
        else if (rs == 5'b00100)                    mtc0 = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    dst_d = 5'd0;
    if (cal_r || jalr || mfhl)       dst_d = rd;
    else if (cal_i || load || mfc0)  dst_d = rt;
    else if (jal)                    dst_d = 5'd31;
  end

  assign rd_rs = (cal_r && !shift_imm) || (cal_i && !lui) || load || store ||
                 branch || jr || jalr || mthl || mdcal;
  assign rd_rt = cal_r || store || beq_bne || mdcal || mtc0;

  function automatic logic reg_hit(stage_t s, logic rd_en, logic [4:0] r);
    return rd_en && (r != 5'd0) && s.vld && (s.dst == r);
  endfunction

  assign use_s1 = reg_hit(stage_p[0], rd_rs, rs) || reg_hit(stage_p[0], rd_rt, rt);
  assign use_s2 = reg_hit(stage_p[1], rd_rs, rs) || reg_hit(stage_p[1], rd_rt, rt);

  assign load_use = use_s1 && stage_p[0].load;
  assign br_haz   = (branch || jr || jalr) && (use_s1 || (use_s2 && stage_p[1].load));
  assign md_haz   = (mdcal || mfhl || mthl) &&
                    ((md_count_p != 5'd0) || (stage_p[0].vld && stage_p[0].mdcal));
  assign epc_haz  = eret && ((stage_p[0].vld && stage_p[0].epc_wr) ||
                             (stage_p[1].vld && stage_p[1].epc_wr));

  assign bus.stall = reset_n && bus.valid_d && (load_use || br_haz || md_haz || epc_haz);

  // Flags are masked with valid_d so a non-instruction never shows a destination
  always_comb begin
    rec_d        = '0;
    rec_d.vld    = bus.valid_d;
    if (bus.valid_d) begin
      rec_d.dst    = dst_d;
      rec_d.load   = load || mfc0;
      rec_d.mdcal  = mdcal;
      rec_d.md_div = md_div;
      rec_d.epc_wr = mtc0 && (rd == 5'd14);
    end
  end

  // Stage 1..DEPTH shift register (E .. W)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < DEPTH; k++) stage_p[k] <= '0;
    end else if (bus.flush) begin
      for (int k = 0; k < DEPTH; k++) stage_p[k] <= '0;
    end else begin
      stage_p[0] <= bus.stall ? '0 : rec_d;
      for (int k = 1; k < DEPTH; k++) stage_p[k] <= stage_p[k-1];
    end
  end

  // HI/LO busy counter; loads one edge after the op reaches E, and ignores flush
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      md_count_p <= 5'd0;
    else if (stage_p[0].vld && stage_p[0].mdcal)
      md_count_p <= stage_p[0].md_div ? 5'(DIV_CYC) : 5'(MULT_CYC);
    else if (md_count_p != 5'd0)
      md_count_p <= md_count_p - 5'd1;
  end

  assign bus.md_count = md_count_p;
  assign bus.md_busy  = (md_count_p != 5'd0);

  for (genvar g = 0; g < DEPTH; g++) begin : g_out
    assign bus.stage_valid[g]         = stage_p[g].vld;
    assign bus.stage_dst[5*g +: 5]    = stage_p[g].dst;
    assign bus.stage_load[g]          = stage_p[g].load;
  end

endmodule

// File: doc/instr_hazard_pipe.md
INSTR_HAZARD_PIPE -- requirements
Module: instr_hazard_pipe

Interface
REQ-001 SHALL have parameter DEPTH, default 3, meaning number of tracked stages after D (stage 1 = E, ..., DEPTH = W); legal range 2..6.
REQ-002 SHALL have parameter MULT_CYC, default 5, meaning busy cycles for mult/multu; legal range 1..31.
REQ-003 SHALL have parameter DIV_CYC, default 10, meaning busy cycles for div/divu; legal range 1..31.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 instr_d  input  32  D-stage instruction word (MIPS encoding).
REQ-007 valid_d  input  1  instr_d holds a real instruction.
REQ-008 flush  input  1  exception/eret flush; kills all tracked stages.
REQ-009 stall  output  1  freeze PC and D register, inject bubble into stage 1.
REQ-010 stage_valid  output  DEPTH  bit k-1 = stage k holds a live instruction.
REQ-011 stage_dst  output  5*DEPTH  destination register per stage; 0 = no write.
REQ-012 stage_load  output  DEPTH  per-stage flag: load or mfc0 (result available only in the last stage).
REQ-013 md_busy  output  1  mult/div unit busy; md_count nonzero.
REQ-014 md_count  output  5  remaining mult/div busy cycles.

Function
REQ-015 SHALL decode instr_d combinationally into: cal_r, cal_i, load, store, branch, jr, jal, jalr, mfhl, mthl, mdcal, mfc0, mtc0, eret, using standard MIPS-I opcode/funct values plus COP0 (op 010000; rs 00000 mfc0, rs 00100 mtc0, funct 011000 eret).
REQ-016 Destination: cal_r/jalr/mfhl use rd; cal_i/load/mfc0 use rt; jal uses 31; all other classes use 0.
REQ-017 Rs is read by cal_r except sll/srl/sra, cal_i except lui, load, store, branch, jr, jalr, mthl, mdcal.
REQ-018 Rt is read by cal_r, store, beq, bne, mdcal, mtc0.
REQ-019 Reads of register 0 SHALL never cause a stall.
REQ-020 Load-use stall: D reads r, and stage 1 is valid with stage_load set and dst == r.
REQ-021 Branch/jump stall: D is branch/jr/jalr reading r, and either stage 1 is valid with dst == r, or stage 2 is valid with stage_load set and dst == r.
REQ-022 Mult/div stall: D is mdcal/mfhl/mthl, and either md_busy is set or stage 1 holds an mdcal.
REQ-023 EPC stall: D is eret, and stage 1 or stage 2 holds an mtc0 with rd == 14.
REQ-024 stall SHALL be the OR of REQ-020..023, gated by valid_d, and combinational with zero latency.
REQ-025 Each edge with flush=0 and stall=0: stage 1 captures {valid_d, decoded flags, dst}; stage k captures stage k-1 for k = 2..DEPTH.
REQ-026 Each edge with stall=1 and flush=0: stage 1 captures a bubble (valid=0, dst=0, flags=0); stages 2..DEPTH still shift.
REQ-027 Each edge with flush=1: every stage_valid clears and every stage_dst zeroes; flush overrides stall.
REQ-028 When an mdcal enters stage 1 (stage 1 captures a valid mdcal), md_count SHALL load MULT_CYC (mult/multu) or DIV_CYC (div/divu) on the next edge.
REQ-029 Otherwise md_count SHALL decrement by 1 per edge while nonzero, and SHALL hold at 0 without wrapping.
REQ-030 flush SHALL NOT alter md_count, since the HI/LO unit keeps running.
REQ-031 Stages with valid=0 SHALL be ignored in every hazard comparison.

Reset
REQ-032 While reset_n=0, all stage registers SHALL clear: stage_valid=0, stage_dst=0, stage_load=0, and md_count=0.
REQ-033 While reset_n=0, md_busy=0 and stall=0.
REQ-034 Reset SHALL take effect immediately; deassertion SHALL be synchronised externally and needs no internal handling.
REQ-035 Reset asserted mid mult/div SHALL zero md_count immediately.

Verification
REQ-036 Load-use: lw $8 then addu $9,$8,$8 -> stall=1 for exactly 1 cycle; stage 1 bubble; addu enters stage 1 one cycle later.
REQ-037 Branch hazard: addu $5 then beq $5,$0 -> stall 1 cycle. lw $5 then beq $5 -> stall 2 cycles.
REQ-038 Mult/div: div then mflo, DIV_CYC=10 -> md_count 10,9,...,0; mflo stalls 11 cycles in total (1 for div in E + 10 busy), then releases.
REQ-039 Flush during stall: lw $8 / addu $8 with flush=1 on the stall cycle -> all stage_valid=0 next cycle; md_count unchanged.
REQ-040 EPC hazard: mtc0 $14 then eret -> stall 2 cycles. mtc0 $12 then eret -> no stall.
REQ-041 $0 and reset: lw $0 then addu $1,$0,$0 -> no stall. reset_n pulled low with md_count=7 -> md_count=0 and stage_valid=0 with no clock edge.
